// File: rtl/stump_control_pkg.sv
// Shared Stump definitions: opcodes, control states, condition codes,
// operand-B source codes and the instruction-register field layout.
package stump_control_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADC  = 3'b001,
    OP_SUB  = 3'b010,
    OP_SBC  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_LDST = 3'b110,
    OP_BCC  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_MEMORY  = 2'b10
  } state_t;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,  COND_NV = 4'd1,
    COND_HI = 4'd2,  COND_LS = 4'd3,
    COND_CC = 4'd4,  COND_CS = 4'd5,
    COND_NE = 4'd6,  COND_EQ = 4'd7,
    COND_VC = 4'd8,  COND_VS = 4'd9,
    COND_PL = 4'd10, COND_MI = 4'd11,
    COND_GE = 4'd12, COND_LT = 4'd13,
    COND_GT = 4'd14, COND_LE = 4'd15
  } cond_t;

  typedef enum logic [1:0] {
    OPB_REG  = 2'b00,
    OPB_IMM5 = 2'b01,
    OPB_IMM8 = 2'b10,
    OPB_ONE  = 2'b11
  } opb_sel_t;

  // Field view of the 16-bit instruction; cond overlays {s, dest}.
  typedef struct packed {
    op_t        op;
    logic       imm;
    logic       s;
    logic [2:0] dest;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] shift;
  } ir_fields_t;

  function automatic logic is_alu_op(input op_t op);
    return (op != OP_LDST) && (op != OP_BCC);
  endfunction

endpackage

// File: rtl/stump_control_cond_eval.sv
// Branch condition evaluator: decides whether Bcc is taken from the
// 4-bit condition field and the current {N,Z,V,C} flags.
module stump_cond_eval
  import stump_control_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       taken
);

  logic n, z, v, c;
  assign {n, z, v, c} = cc;

  // NOTE: combinational blocks assign every output first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    taken = 1'b0;
    case (cond_t'(cond))
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_CC: taken = ~c;
      COND_CS: taken = c;
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_VC: taken = ~v;
      COND_VS: taken = v;
      COND_PL: taken = ~n;
      COND_MI: taken = n;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/stump_control.sv
// Stump multi-cycle control unit: sequences FETCH/EXECUTE/MEMORY from the
// IR, drives datapath strobes and owns the condition-code register.
module stump_control
  import stump_control_pkg::*;
#(
  parameter logic [2:0] PC_REG   = 3'd7,
  parameter logic [3:0] CC_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [3:0]  flags_in,
  output logic [1:0]  state,
  output logic        fetch,
  output logic        ir_en,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [1:0]  opb_sel,
  output logic [1:0]  shift_op,
  output logic [2:0]  alu_func,
  output logic        c_in,
  output logic [3:0]  cc,
  output logic        addr_en,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic        wdata_sel
);

  state_t     state_q, state_d;
  logic [3:0] cc_q;
  ir_fields_t f;
  logic       taken;

  assign f     = ir_fields_t'(ir);
  assign state = state_q;
  assign cc    = cc_q;

  stump_cond_eval u_cond_eval (
    .cond  ({f.s, f.dest}),
    .cc    (cc_q),
    .taken (taken)
  );

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FETCH;
    else      state_q <= state_d;
  end

  // Flags are only committed by an S-suffixed ALU op completing EXECUTE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cc_q <= CC_RESET;
    end else if (state_q == ST_EXECUTE && is_alu_op(f.op) && f.s) begin
      cc_q <= flags_in;
    end
  end

  always_comb begin
    state_d   = ST_FETCH;
    fetch     = 1'b0;
    ir_en     = 1'b0;
    reg_write = 1'b0;
    dest      = f.dest;
    srcA      = f.a;
    srcB      = f.b;
    opb_sel   = OPB_REG;
    shift_op  = 2'b00;
    alu_func  = OP_ADD;
    c_in      = 1'b0;
    addr_en   = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    wdata_sel = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // PC <= PC + 1 while the instruction is read.
        fetch     = 1'b1;
        ir_en     = 1'b1;
        srcA      = PC_REG;
        opb_sel   = OPB_ONE;
        reg_write = 1'b1;
        dest      = PC_REG;
        state_d   = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        opb_sel  = f.imm ? OPB_IMM5 : OPB_REG;
        shift_op = f.imm ? 2'b00 : f.shift;
        c_in     = ((f.op == OP_ADC) || (f.op == OP_SBC)) && cc_q[0];
        case (f.op)
          OP_LDST: begin
            addr_en = 1'b1;
            state_d = ST_MEMORY;
          end
          OP_BCC: begin
            srcA      = PC_REG;
            opb_sel   = OPB_IMM8;
            shift_op  = 2'b00;
            dest      = PC_REG;
            reg_write = taken;
          end
          default: begin
            alu_func  = f.op;
            reg_write = 1'b1;
          end
        endcase
      end

      ST_MEMORY: begin
        if (f.s) begin
          mem_wen = 1'b1;
          srcB    = f.dest;
        end else begin
          mem_ren   = 1'b1;
          reg_write = 1'b1;
          wdata_sel = 1'b1;
        end
      end

      default: state_d = ST_FETCH;
    endcase

    // Reset must suppress every state-changing strobe immediately.
    if (!rst) begin
      ir_en     = 1'b0;
      reg_write = 1'b0;
      addr_en   = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
    end
  end

endmodule

// File: tb/tb_stump_control.sv
// Self-checking bench for stump_control: an instruction-level reference
// model compared every cycle, plus directed literal checks.
module tb_stump_control;

  logic        clk, rst;
  logic [15:0] ir;
  logic [3:0]  flags_in;
  logic [1:0]  state;
  logic        fetch, ir_en, reg_write;
  logic [2:0]  dest, srcA, srcB;
  logic [1:0]  opb_sel, shift_op;
  logic [2:0]  alu_func;
  logic        c_in;
  logic [3:0]  cc;
  logic        addr_en, mem_ren, mem_wen, wdata_sel;

  int n_cmp = 0;
  int n_bad = 0;

  stump_control dut (
    .clk(clk), .rst(rst), .ir(ir), .flags_in(flags_in), .state(state),
    .fetch(fetch), .ir_en(ir_en), .reg_write(reg_write), .dest(dest),
    .srcA(srcA), .srcB(srcB), .opb_sel(opb_sel), .shift_op(shift_op),
    .alu_func(alu_func), .c_in(c_in), .cc(cc), .addr_en(addr_en),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .wdata_sel(wdata_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bcc conditions come in complementary pairs: odd codes invert the even one.
  function automatic logic ref_taken(input logic [3:0] cnd, input logic [3:0] c);
    logic n, z, v, cy, base;
    {n, z, v, cy} = c;
    case (cnd[3:1])
      3'd0:    base = 1'b1;
      3'd1:    base = cy & ~z;
      3'd2:    base = ~cy;
      3'd3:    base = ~z;
      3'd4:    base = ~v;
      3'd5:    base = ~n;
      3'd6:    base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ cnd[0];
  endfunction

  typedef struct packed {
    logic [1:0] state;
    logic       fetch, ir_en, reg_write;
    logic [2:0] dest, srca, srcb;
    logic [1:0] opb_sel, shift_op;
    logic [2:0] alu_func;
    logic       c_in, addr_en, mem_ren, mem_wen, wdata_sel;
  } exp_t;

  // Instruction-level reference: phase 0 = fetch, 1 = execute, 2 = memory.
  int         m_phase;
  logic [3:0] m_cc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_cc    <= 4'b0000;
    end else begin
      case (m_phase)
        0: m_phase <= 1;
        1: begin
          if (ir[15:13] <= 3'd5 && ir[11]) m_cc <= flags_in;
          m_phase <= (ir[15:13] == 3'd6) ? 2 : 0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  function automatic exp_t model_out(input int ph, input logic [3:0] c,
                                     input logic [15:0] i, input logic r);
    exp_t e;
    logic [2:0] op;
    op     = i[15:13];
    e      = '0;
    e.state = ph[1:0];
    e.dest = i[10:8];
    e.srca = i[7:5];
    e.srcb = i[4:2];
    if (ph == 0) begin
      e.fetch = 1'b1; e.ir_en = 1'b1; e.reg_write = 1'b1;
      e.dest = 3'd7; e.srca = 3'd7; e.opb_sel = 2'd3;
    end else if (ph == 1) begin
      e.opb_sel  = i[12] ? 2'd1 : 2'd0;
      e.shift_op = i[12] ? 2'd0 : i[1:0];
      e.c_in     = (op == 3'd1 || op == 3'd3) ? c[0] : 1'b0;
      if (op <= 3'd5) begin
        e.alu_func = op; e.reg_write = 1'b1;
      end else if (op == 3'd6) begin
        e.addr_en = 1'b1;
      end else begin
        e.srca = 3'd7; e.dest = 3'd7; e.opb_sel = 2'd2; e.shift_op = 2'd0;
        e.reg_write = ref_taken(i[11:8], c);
      end
    end else if (ph == 2) begin
      if (i[11]) begin
        e.mem_wen = 1'b1; e.srcb = i[10:8];
      end else begin
        e.mem_ren = 1'b1; e.reg_write = 1'b1; e.wdata_sel = 1'b1;
      end
    end
    if (!r) begin
      e.ir_en = 1'b0; e.reg_write = 1'b0; e.addr_en = 1'b0;
      e.mem_ren = 1'b0; e.mem_wen = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    e = model_out(m_phase, m_cc, ir, rst);
    check("m.state",     32'(state),     32'(e.state));
    check("m.fetch",     32'(fetch),     32'(e.fetch));
    check("m.ir_en",     32'(ir_en),     32'(e.ir_en));
    check("m.reg_write", 32'(reg_write), 32'(e.reg_write));
    check("m.dest",      32'(dest),      32'(e.dest));
    check("m.srcA",      32'(srcA),      32'(e.srca));
    check("m.srcB",      32'(srcB),      32'(e.srcb));
    check("m.opb_sel",   32'(opb_sel),   32'(e.opb_sel));
    check("m.shift_op",  32'(shift_op),  32'(e.shift_op));
    check("m.alu_func",  32'(alu_func),  32'(e.alu_func));
    check("m.c_in",      32'(c_in),      32'(e.c_in));
    check("m.cc",        32'(cc),        32'(m_cc));
    check("m.addr_en",   32'(addr_en),   32'(e.addr_en));
    check("m.mem_ren",   32'(mem_ren),   32'(e.mem_ren));
    check("m.mem_wen",   32'(mem_wen),   32'(e.mem_wen));
    check("m.wdata_sel", 32'(wdata_sel), 32'(e.wdata_sel));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs ADD with S=1 so the CC register ends up holding v; starts and ends in FETCH.
  task automatic set_cc(input logic [3:0] v);
    ir = 16'h094C;
    flags_in = v;
    step();
    step();
  endtask

  task automatic bcc_check(input string name, input logic [15:0] i, input logic exp_taken);
    ir = i;
    step();
    check(name, 32'(reg_write), 32'(exp_taken));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ir = 16'h0000;
    flags_in = 4'b0000;
    #2;
    check("rst.state", 32'(state), 32'd0);
    check("rst.cc",    32'(cc),    32'd0);
    check("rst.ir_en", 32'(ir_en), 32'd0);
    check("rst.fetch", 32'(fetch), 32'd1);
    #5 rst = 1'b1;
    #1;
    check("rel.fetch", 32'(fetch), 32'd1);
    check("rel.ir_en", 32'(ir_en), 32'd1);

    // ADD S=1 d1,a2,b3
    ir = 16'h094C; flags_in = 4'b0101;
    step();
    check("add.state",     32'(state),     32'd1);
    check("add.alu_func",  32'(alu_func),  32'd0);
    check("add.srcA",      32'(srcA),      32'd2);
    check("add.srcB",      32'(srcB),      32'd3);
    check("add.opb_sel",   32'(opb_sel),   32'd0);
    check("add.reg_write", 32'(reg_write), 32'd1);
    check("add.dest",      32'(dest),      32'd1);
    step();
    check("add.cc",        32'(cc),        32'h5);
    check("add.next",      32'(state),     32'd0);

    // SBC immediate, S=0: carry-in from CC, CC untouched
    set_cc(4'b0001);
    ir = 16'h74BF; flags_in = 4'b1110;
    step();
    check("sbc.alu_func", 32'(alu_func), 32'd3);
    check("sbc.c_in",     32'(c_in),     32'd1);
    check("sbc.opb_sel",  32'(opb_sel),  32'd1);
    check("sbc.shift_op", 32'(shift_op), 32'd0);
    step();
    check("sbc.cc",       32'(cc),       32'h1);

    // LD d2,[a3]
    ir = 16'hC260;
    step();
    check("ld.ex.state",   32'(state),     32'd1);
    check("ld.ex.addr_en", 32'(addr_en),   32'd1);
    check("ld.ex.reg_wr",  32'(reg_write), 32'd0);
    step();
    check("ld.mem.state",  32'(state),     32'd2);
    check("ld.mem.ren",    32'(mem_ren),   32'd1);
    check("ld.mem.reg_wr", 32'(reg_write), 32'd1);
    check("ld.mem.dest",   32'(dest),      32'd2);
    check("ld.mem.wsel",   32'(wdata_sel), 32'd1);
    step();
    check("ld.done.state", 32'(state),     32'd0);

    // ST d2,[a3]
    ir = 16'hCA60;
    step();
    step();
    check("st.mem.wen",    32'(mem_wen),   32'd1);
    check("st.mem.srcB",   32'(srcB),      32'd2);
    check("st.mem.reg_wr", 32'(reg_write), 32'd0);
    check("st.mem.ren",    32'(mem_ren),   32'd0);
    step();

    // Reset while an LD sits in MEMORY
    ir = 16'hC260;
    step();
    step();
    #1 rst = 1'b0;
    #1;
    check("ldrst.state",  32'(state),     32'd0);
    check("ldrst.cc",     32'(cc),        32'd0);
    check("ldrst.ren",    32'(mem_ren),   32'd0);
    check("ldrst.reg_wr", 32'(reg_write), 32'd0);
    check("ldrst.ir_en",  32'(ir_en),     32'd0);
    step();
    rst = 1'b1;
    #1;
    check("ldrst.fetch",  32'(fetch),     32'd1);
    check("ldrst.ir_en1", 32'(ir_en),     32'd1);
    check("ldrst.state1", 32'(state),     32'd0);

    // BEQ
    set_cc(4'b0100);
    ir = 16'hE7F0;
    step();
    check("beq.t.reg_wr",  32'(reg_write), 32'd1);
    check("beq.t.dest",    32'(dest),      32'd7);
    check("beq.t.opb_sel", 32'(opb_sel),   32'd2);
    step();
    set_cc(4'b0000);
    bcc_check("beq.nt.reg_wr", 16'hE7F0, 1'b0);

    // BNV is never taken
    for (int v = 0; v < 16; v++) begin
      set_cc(4'(v));
      bcc_check("bnv.reg_wr", 16'hE1F0, 1'b0);
    end

    // Signed comparisons
    set_cc(4'b1010);
    bcc_check("bgt.1010", 16'hEE05, 1'b1);
    bcc_check("ble.1010", 16'hEF05, 1'b0);
    bcc_check("blt.1010", 16'hED05, 1'b0);
    set_cc(4'b1110);
    bcc_check("ble.1110", 16'hEF05, 1'b1);
    bcc_check("bgt.1110", 16'hEE05, 1'b0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stump_control.md
Name: stump_control

Overview:
Multi-cycle control unit and condition-code register for the Stump datapath. It sits directly upstream of the Stump ALU, driving its `func` and `c_in` inputs. It sits directly downstream of the ALU's `flags_out`, which it latches into the CC register. From the instruction register it sequences FETCH/EXECUTE/MEMORY and produces register-bank, operand-mux and memory strobes.

Parameters:
PC_REG, 3'd7, register-bank index used as program counter
CC_RESET, 4'b0000, CC register value on reset ({N,Z,V,C})

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
ir  in  16  instruction register contents, valid from EXECUTE until next FETCH
flags_in  in  4  ALU flags_out {N,Z,V,C}
state  out  2  current state: 00 FETCH, 01 EXECUTE, 10 MEMORY
fetch  out  1  memory address from PC, instruction read
ir_en  out  1  load IR at end of cycle
reg_write  out  1  write register bank at end of cycle
dest  out  3  write register index
srcA  out  3  operand A register index
srcB  out  3  operand B register index
opb_sel  out  2  operand B source: 00 reg, 01 sext imm5 ir[4:0], 10 sext imm8 ir[7:0], 11 constant 1
shift_op  out  2  shifter control (00 = none)
alu_func  out  3  to ALU func
c_in  out  1  to ALU c_in
cc  out  4  CC register {N,Z,V,C}
addr_en  out  1  latch ALU result into address register
mem_ren  out  1  data memory read
mem_wen  out  1  data memory write
wdata_sel  out  1  register write data: 0 ALU result, 1 memory data

Behaviour:
- Only `state` and `cc` are registered. All other outputs are combinational from `state`, `ir` and `cc`.
- While `rst` = 0, asynchronously:
  - `state` = FETCH and `cc` = CC_RESET.
  - `ir_en`, `reg_write`, `addr_en`, `mem_ren` and `mem_wen` are forced to 0.
  - Other outputs take their FETCH values.
- Reset asserted mid-instruction abandons it. No partial CC update occurs.
- IR decode:
  - op = ir[15:13]; type = ir[12] (1 = immediate); S/store = ir[11].
  - dest = ir[10:8]; A = ir[7:5]; B = ir[4:2]; shift = ir[1:0]; cond = ir[11:8].
- FETCH:
  - `fetch` = 1, `ir_en` = 1.
  - srcA = PC_REG, opb_sel = 11, alu_func = ADD.
  - reg_write = 1, dest = PC_REG, wdata_sel = 0.
  - Next state: EXECUTE.
- EXECUTE, op 000–101 (ALU ops):
  - alu_func = op, srcA = A, srcB = B, dest = dest.
  - reg_write = 1, wdata_sel = 0.
  - opb_sel = type ? 01 : 00; shift_op = type ? 00 : shift.
  - CC loads `flags_in` at the clock edge iff S = 1.
  - Next state: FETCH.
- EXECUTE, op 110 (LD/ST):
  - alu_func = ADD, srcA = A, opb_sel as for ALU ops, `addr_en` = 1.
  - reg_write = 0; CC unchanged.
  - Next state: MEMORY.
- EXECUTE, op 111 (Bcc):
  - alu_func = ADD, srcA = PC_REG, opb_sel = 10, dest = PC_REG.
  - reg_write = taken(cond, cc); CC unchanged.
  - Next state: FETCH.
- MEMORY:
  - Load (S = 0): mem_ren = 1, reg_write = 1, dest = ir[10:8], wdata_sel = 1.
  - Store (S = 1): mem_wen = 1, srcB = ir[10:8] (store data), reg_write = 0.
  - Next state: FETCH.
- Illegal state 11: all strobes 0; next state FETCH.
- c_in = cc[0] when op is ADC (001) or SBC (011), else 0. It always uses the pre-update CC value.
- Latency per instruction: ALU ops and Bcc take 2 cycles; LD/ST take 3 cycles.
- Condition codes, cond 0–15:
  - 0 AL, 1 NV
  - 2 HI (C&!Z), 3 LS (!C|Z)
  - 4 CC (!C), 5 CS (C)
  - 6 NE (!Z), 7 EQ (Z)
  - 8 VC (!V), 9 VS (V)
  - 10 PL (!N), 11 MI (N)
  - 12 GE (N==V), 13 LT (N!=V)
  - 14 GT (!Z&(N==V)), 15 LE (Z|(N!=V))

Decomposition:
- Shared `Stump_definitions` holds:
  - Opcode codes (ADD…BCC).
  - State codes FETCH/EXECUTE/MEMORY.
  - The 16 condition codes.
  - opb_sel codes.
- One natural sub-module: `stump_cond_eval`, a combinational (cond[3:0], cc[3:0]) → taken function, instantiated once.

Test Plan:
- Reset in MEMORY of an LD: rst=0 → `state` 00, `cc` 0000, mem_ren/reg_write 0 immediately. After rst=1, first cycle has fetch=1, ir_en=1.
- ir=0x094C (ADD S=1, d1,a2,b3), flags_in=0101:
  - EXECUTE: alu_func 000, srcA 2, srcB 3, opb_sel 00, reg_write 1, dest 1.
  - After the edge: cc=0101, state FETCH.
- cc=0001, ir=0x74BF (SBC imm, S=0, d4,a5,imm 11111):
  - alu_func 011, c_in 1, opb_sel 01, shift_op 00.
  - cc remains 0001 whatever `flags_in` is.
- ir=0xC260 (LD d2,a3):
  - EXECUTE: addr_en 1, reg_write 0.
  - MEMORY: mem_ren 1, reg_write 1, dest 2, wdata_sel 1.
  - FETCH on the 3rd edge.
  - ir=0xCA60 (ST): MEMORY has mem_wen 1, srcB 2, reg_write 0.
- Bcc EQ ir=0xE7F0: with cc=0100 → reg_write 1, dest 7, opb_sel 10; with cc=0000 → reg_write 0. ir=0xE1F0 (NV) → reg_write 0 for all 16 cc values.
- cc=1010 (N=1, V=1): BGT ir=0xEE05 taken; BLE ir=0xEF05 not taken; BLT ir=0xED05 not taken. Repeat with cc=1110: BLE taken, BGT not taken.
